// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/uart_fifo.sv
// Register-based synchronous byte queue feeding the UART shifter.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Acceptance uses the occupancy before the edge, so a full queue drops the write
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: queued bytes are framed and shifted out LSB first on tx.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              busy,
  output logic              tx
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  uart_state_t                  state;
  uart_state_t                  state_next;
  logic [TMR_W-1:0]             timer;
  logic [TMR_W-1:0]             timer_next;
  logic [2:0]                   bit_idx;
  logic [2:0]                   bit_idx_next;
  logic [DATA_W-1:0]            shift_reg;
  logic [DATA_W-1:0]            shift_next;
  logic [DATA_W-1:0]            fifo_data;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         tx_next;
  logic                         pop;
  logic                         bit_done;

  uart_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bit_done = (timer == TMR_LAST);
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    state_next   = state;
    timer_next   = timer + 1'b1;
    bit_idx_next = bit_idx;
    pop          = 1'b0;
    shift_next   = shift_reg;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_next = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_next = '0;
          if (bit_idx == 3'd7) state_next   = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_next = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (pop) begin
      bit_idx_next = '0;
      shift_next   = fifo_data;
    end

    // tx is registered from the next state, so it changes on the same edge as the FSM
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_next;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: framing, queueing, reset abort and long bit timing.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       busy;
  logic       tx;
  logic       wr_en87;
  logic [7:0] wr_data87;
  logic       full87;
  logic       empty87;
  logic       busy87;
  logic       tx87;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic txlog[$];
  logic txlog87[$];

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .busy      (busy),
    .tx        (tx)
  );

  uart_transmitter #(.CLKS_PER_BIT(87), .FIFO_DEPTH(4)) dut87 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en87),
    .wr_data   (wr_data87),
    .fifo_full (full87),
    .fifo_empty(empty87),
    .busy      (busy87),
    .tx        (tx87)
  );

  // log[k] holds tx as seen after edge k, where edge 0 is the first write
  always @(negedge clk) begin
    if (mon_en) begin
      txlog.push_back(tx);
      txlog87.push_back(tx87);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_start();
    txlog.delete();
    txlog87.delete();
    mon_en = 1'b1;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    step();
    check({tag, "_tx"},    32'(tx),         32'd1);
    check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    check({tag, "_full"},  32'(fifo_full),  32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    rst = 1'b0;
  endtask

  // Bit i of the observed pattern is the i-th transmitted bit; unstable bits read as x
  task automatic check_frame(input string tag, input int start, input logic [9:0] exp);
    logic [9:0] obs;
    logic       v;
    obs = 'x;
    if (start + 39 < txlog.size()) begin
      for (int i = 0; i < 10; i++) begin
        v = txlog[start + 4*i];
        for (int j = 1; j < 4; j++)
          if (txlog[start + 4*i + j] !== v) v = 1'bx;
        obs[i] = v;
      end
    end
    check(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    logic [7:0] bytes6 [6];
    logic [3:0] tail;
    int         zeros;
    int         idle_busy;
    int         low_run;
    int         high_run;
    int         idx;

    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    wr_en87   = 1'b0;
    wr_data87 = 8'h00;
    step();
    apply_reset("rst0");
    check("rst0_busy87", 32'(busy87), 32'd0);
    check("rst0_tx87",   32'(tx87),   32'd1);

    // Single byte 0xA5
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    step();
    wr_en   = 1'b0;
    wr_data = 8'h5A;
    log_start();
    check("a5_tx_edge0",    32'(tx),         32'd1);
    check("a5_empty_edge0", 32'(fifo_empty), 32'd0);
    check("a5_busy_edge0",  32'(busy),       32'd1);
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k == 1)  check("a5_tx_edge1",   32'(tx),   32'd0);
      if (k == 40) check("a5_busy_edge40", 32'(busy), 32'd1);
      if (k == 41) begin
        check("a5_tx_edge41",   32'(tx),   32'd1);
        check("a5_busy_edge41", 32'(busy), 32'd0);
      end
    end
    check("a5_idle_before", 32'(txlog[0]), 32'd1);
    check_frame("a5_frame", 1, 10'b1_1010_0101_0);

    // Three back-to-back bytes
    apply_reset("rst1");
    wr_en = 1'b1;
    wr_data = 8'h00; step(); log_start();
    wr_data = 8'hFF; step();
    wr_data = 8'h55; step();
    wr_en = 1'b0;
    for (int k = 3; k <= 122; k++) begin
      step();
      if (k == 120) check("b2b_busy_edge120", 32'(busy), 32'd1);
    end
    check_frame("b2b_frame0_00", 1,  10'b1_0000_0000_0);
    check_frame("b2b_frame1_ff", 41, 10'b1_1111_1111_0);
    check_frame("b2b_frame2_55", 81, 10'b1_0101_0101_0);
    check("b2b_idle_edge121", 32'(txlog[121]), 32'd1);
    check("b2b_busy_edge122", 32'(busy), 32'd0);

    // Six writes into a depth-4 queue: the sixth is dropped
    apply_reset("rst2");
    bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = bytes6[i];
      step();
      if (i == 0) log_start();
      if (i == 1) check("ovf_empty_edge1", 32'(fifo_empty), 32'd0);
      if (i == 3) check("ovf_full_edge3",  32'(fifo_full),  32'd0);
      if (i == 4) check("ovf_full_edge4",  32'(fifo_full),  32'd1);
      if (i == 5) check("ovf_full_edge5",  32'(fifo_full),  32'd1);
    end
    wr_en   = 1'b0;
    wr_data = 8'hEE;
    for (int k = 6; k <= 205; k++) begin
      step();
      if (k == 41) check("ovf_full_edge41", 32'(fifo_full), 32'd0);
    end
    check_frame("ovf_frame0_11", 1,   10'b1_0001_0001_0);
    check_frame("ovf_frame1_22", 41,  10'b1_0010_0010_0);
    check_frame("ovf_frame2_33", 81,  10'b1_0011_0011_0);
    check_frame("ovf_frame3_44", 121, 10'b1_0100_0100_0);
    check_frame("ovf_frame4_55", 161, 10'b1_0101_0101_0);
    tail = {txlog[204], txlog[203], txlog[202], txlog[201]};
    check("ovf_no_sixth_frame", 32'(tail), 32'hF);
    check("ovf_busy_end",  32'(busy),       32'd0);
    check("ovf_empty_end", 32'(fifo_empty), 32'd1);

    // Reset at cycle 18 of a 0x3C frame with two bytes queued
    apply_reset("rst3");
    wr_en = 1'b1;
    wr_data = 8'h3C; step(); log_start();
    wr_data = 8'h01; step();
    wr_data = 8'h02; step();
    wr_en = 1'b0;
    for (int k = 3; k <= 17; k++) step();
    check("abort_empty_before", 32'(fifo_empty), 32'd0);
    check("abort_busy_before",  32'(busy),       32'd1);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    rst   = 1'b0;
    wr_en = 1'b0;
    check("abort_tx",    32'(tx),         32'd1);
    check("abort_empty", 32'(fifo_empty), 32'd1);
    check("abort_full",  32'(fifo_full),  32'd0);
    check("abort_busy",  32'(busy),       32'd0);
    zeros     = 0;
    idle_busy = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx !== 1'b1)   zeros++;
      if (busy !== 1'b0) idle_busy++;
    end
    check("abort_no_restart", 32'(zeros),     32'd0);
    check("abort_stay_idle",  32'(idle_busy), 32'd0);

    // Long bit period: byte 0x80 at 87 clocks per bit
    wr_en87   = 1'b1;
    wr_data87 = 8'h80;
    step();
    wr_en87   = 1'b0;
    log_start();
    for (int k = 1; k <= 871; k++) begin
      step();
      if (k == 870) check("b87_busy_edge870", 32'(busy87), 32'd1);
      if (k == 871) begin
        check("b87_busy_edge871", 32'(busy87), 32'd0);
        check("b87_tx_edge871",   32'(tx87),   32'd1);
      end
    end
    mon_en = 1'b0;
    check("b87_idle_edge0", 32'(txlog87[0]), 32'd1);
    low_run  = 0;
    high_run = 0;
    idx      = 1;
    while (idx < txlog87.size() && txlog87[idx] === 1'b0) begin
      low_run++;
      idx++;
    end
    while (idx < txlog87.size() && txlog87[idx] === 1'b1) begin
      high_run++;
      idx++;
    end
    // start bit plus data bits 0..6 are all low: 8 * 87 cycles
    check("b87_low_run",  32'(low_run),  32'd696);
    // data bit 7 plus stop bit: 2 * 87 cycles, ending at edge 870
    check("b87_high_run", 32'(high_run), 32'd174);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
